// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO store-capture block: default decode
// constants, the run/drain/halt state encoding and the FIFO entry width.
// Optional feature macro: MMIO_CAPTURE_TIMESTAMP_EN (adds a 32-bit cycle
// stamp to every captured entry, widening entries from 64 to 96 bits).
package mmio_pkg;

    localparam int          MMIO_BIT_DEF  = 11;
    localparam logic [31:0] HALT_ADDR_DEF = 32'h0000_0FFC;

    // Explicit two-bit encoding keeps the state values stable across tools.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

`ifdef MMIO_CAPTURE_TIMESTAMP_EN
    // {stamp, address, data}
    localparam int ENTRY_W = 96;
`else
    // {address, data}
    localparam int ENTRY_W = 64;
`endif

endpackage : mmio_pkg

// File: rtl/mmio_write_capture_fifo.sv
// First-word-fall-through synchronous FIFO. Pointers carry one extra wrap
// bit so that full and empty are distinguishable when the indices match.
// A push while full is accepted only if a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head entry falls through combinationally from storage.
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Advance read/write pointers; clearing them empties the FIFO.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; the pointers alone decide
        // which slots hold valid data, and an unreset array maps to RAM.
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule : sync_fifo

// File: rtl/mmio_write_capture.sv
// Passive snooper on the core<->memory bus. Stores into the MMIO window are
// queued in a FWFT FIFO and offered to a sink over valid/ready. An access to
// the halt address stops capture, lets the FIFO drain, then raises done.
// Optional feature macro: MMIO_CAPTURE_TIMESTAMP_EN (adds out_stamp, the
// free-running cycle count sampled at the capturing edge).
module mmio_write_capture
    import mmio_pkg::*;
#(
    parameter int          DEPTH     = 8,
    parameter int          MMIO_BIT  = MMIO_BIT_DEF,
    parameter logic [31:0] HALT_ADDR = HALT_ADDR_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] address,
    input  logic [31:0] data_out,
    input  logic        we,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_addr,
    output logic [31:0] out_data,
`ifdef MMIO_CAPTURE_TIMESTAMP_EN
    output logic [31:0] out_stamp,
`endif
    output logic        overflow,
    output logic [31:0] wr_count,
    output logic        done
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t             state;
    logic               is_halt;
    logic               capture;
    logic               push;
    logic               pop;
    logic               drop;
    logic               drained;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head;

    assign is_halt = (address == HALT_ADDR);
    assign capture = (state == ST_RUN) && we && address[MMIO_BIT] && !is_halt;
    assign pop     = !fifo_empty && out_ready;
    // A full FIFO still takes a capture when the head leaves on the same edge.
    assign push    = capture && (!fifo_full || pop);
    assign drop    = capture && fifo_full && !pop;
    // FIFO is empty once this edge's pop (if any) completes; no pushes
    // happen outside RUN, so only the pop can change occupancy here.
    assign drained = fifo_empty || (pop && (fifo_count == CW'(1)));

`ifdef MMIO_CAPTURE_TIMESTAMP_EN
    logic [31:0] cycle_cnt;

    // Free-running cycle counter used to stamp captured entries.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cycle_cnt <= '0;
        else         cycle_cnt <= cycle_cnt + 32'd1;
    end

    assign wr_entry  = {cycle_cnt, address, data_out};
    assign out_stamp = out_valid ? head[95:64] : 32'd0;
`else
    assign wr_entry  = {address, data_out};
`endif

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push    (push),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Head is masked to zero whenever nothing is being offered.
    assign out_valid = !fifo_empty;
    assign out_addr  = out_valid ? head[63:32] : 32'd0;
    assign out_data  = out_valid ? head[31:0]  : 32'd0;

    // Run -> drain on the halt access, drain -> halted once the FIFO empties.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN:    if (is_halt) state <= ST_DRAIN;
                ST_DRAIN:  if (drained) state <= ST_HALTED;
                ST_HALTED: state <= ST_HALTED;
                default:   state <= ST_RUN;
            endcase
        end
    end

    // done is registered alongside the transition into HALTED.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                            done <= 1'b0;
        else if (state == ST_DRAIN && drained)  done <= 1'b1;
    end

    // Accepted-capture counter (wraps) and sticky drop flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_count <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_count <= wr_count + 32'd1;
            if (drop) overflow <= 1'b1;
        end
    end

endmodule : mmio_write_capture
